// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor front end.
//   - Default widths and the reset PC of the fetch stage.
//   - Fetch FSM state encoding as plain 2-bit constants.
//   - A NOP instruction word, used to pre-load memories and benches.
package cpu_pkg;

    localparam int          PC_W_DEF     = 8;
    localparam int          INSTR_W_DEF  = 32;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;

    // Fetch FSM encoding
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_FULL = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle.
// Carries the instruction-memory read handshake (mem_req/mem_addr/mem_ack/
// mem_rdata) and the downstream instruction handshake (instr/instr_pc/
// instr_valid/instr_ready).
//   master : the fetch stage (drives requests and the instruction buffer)
//   slave  : the environment (memory + decode), answers ack/rdata/ready
interface instr_fetch_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
);
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_counter.sv
// Program counter register.
//   clk, rst    : clock, synchronous active-high reset (loads RESET_PC)
//   load_i      : load load_val_i (redirect); takes priority over inc_i
//   load_val_i  : new PC value
//   inc_i       : advance by PC_STEP, wrapping modulo 2^PC_W
//   pc_o        : current PC
module pc_counter #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + STEP;   // natural wrap of the PC_W-bit sum
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Issues one word-addressed read at a time, captures the returned word into a
// single-entry buffer and hands it downstream with valid/ready. A redirect
// reloads the PC and flushes both the buffer and any outstanding read.
//   clk, rst         : clock, synchronous active-high reset
//   en               : fetch enable; 0 stops new requests (an outstanding one
//                      still completes and is delivered)
//   redirect         : load redirect_target into the PC, flush
//   redirect_target  : new PC
//   bus (master)     : memory read handshake + downstream instruction handshake
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int              PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_target,
    instr_fetch_if.master     bus
);
    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic [PC_W-1:0]    pc;
    logic               pc_load;
    logic               pc_inc;

    pc_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (redirect_target),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;

        if (redirect) begin
            // Flush wins over ack and ready; a same-cycle ack is dropped and
            // the PC does not advance. The buffer contents are left as-is,
            // only their valid flag (derived from the state) goes away.
            pc_load = 1'b1;
            state_d = en ? ST_REQ : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (bus.mem_ack) begin
                        instr_d    = bus.mem_rdata;
                        instr_pc_d = pc;
                        pc_inc     = 1'b1;
                        state_d    = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.instr_ready) begin
                        state_d = en ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // The buffer is occupied exactly when the FSM sits in FULL, so valid is
    // decoded from the state rather than kept in a separate flop.
    assign bus.mem_req     = (state_q == ST_REQ);
    assign bus.mem_addr    = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (state_q == ST_FULL);
endmodule
